// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: memory-stage data-memory controller for a 16-bit async SRAM.
//
// Turns a single-cycle 32-bit load/store request into two 16-bit half
// accesses, low half first. Each half is held on the pins for WAIT_CYCLES
// cycles. ready stays low while a request is being served, and the pipeline
// is frozen with ~ready.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   wr_en, rd_en        store / load request, held while ready=0
//   address             byte address; bits [1:0] ignored
//   write_data          store data
//   read_data           registered load result
//   ready               combinational; 0 = stall pipeline
//   sram_addr           SRAM 16-bit word address
//   sram_dq_out/_in/_oe data pad out, in and output enable
//   sram_we_n, sram_oe_n active-low write / output enable
//
// Optional feature (macro SRAM_ACCESS_COUNT_EN): adds rd_count/wr_count,
// which count completed loads and stores.
module sram_mem_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  output logic        sram_oe_n
`ifdef SRAM_ACCESS_COUNT_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        op_wr;
  logic [31:0] offset;
  logic        last_cyc;
  logic        unused_offset_bits;

  // Addresses below BASE_ADDR simply wrap; only offset[18:2] reaches the pins.
  assign offset             = address - BASE_ADDR;
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
  assign last_cyc           = (cnt == LAST_CNT);

  assign ready = (~rd_en & ~wr_en) | (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      op_wr     <= 1'b0;
      read_data <= 32'd0;
`ifdef SRAM_ACCESS_COUNT_EN
      rd_count  <= 32'd0;
      wr_count  <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (rd_en | wr_en) begin
            state <= LOW;
            cnt   <= 4'd0;
            op_wr <= wr_en;   // store wins when both are requested
          end
        end
        LOW: begin
          if (last_cyc) begin
            state <= HIGH;
            cnt   <= 4'd0;
            if (!op_wr) read_data[15:0] <= sram_dq_in;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HIGH: begin
          if (last_cyc) begin
            state <= DONE;
            cnt   <= 4'd0;
            if (!op_wr) read_data[31:16] <= sram_dq_in;
`ifdef SRAM_ACCESS_COUNT_EN
            if (op_wr) wr_count <= wr_count + 32'd1;
            else       rd_count <= rd_count + 32'd1;
`endif
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Pin decode from the registered state and latched operation.
  always_comb begin
    sram_addr   = 18'd0;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    if (state == LOW || state == HIGH) begin
      sram_addr = {offset[18:2], (state == HIGH)};
      if (op_wr) begin
        sram_we_n   = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_dq_out = (state == HIGH) ? write_data[31:16] : write_data[15:0];
      end else begin
        sram_oe_n = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
module tb_sram_mem_ctrl;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        sram_oe_n;
`ifdef SRAM_ACCESS_COUNT_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  sram_mem_ctrl #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
`ifdef SRAM_ACCESS_COUNT_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: 1K words is enough for the addresses used here.
  logic [15:0] mem [0:1023];
  always @(posedge clk)
    if (!sram_we_n && sram_dq_oe) mem[sram_addr[9:0]] <= sram_dq_out;
  assign sram_dq_in = sram_oe_n ? 16'h0000 : mem[sram_addr[9:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int exp_rdc = 0;
  int exp_wrc = 0;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;    // read_data expected in DONE
    logic [17:0] exp_base;  // sram_addr expected in LOW
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_pins(input string tag);
    chk({tag, " we_n"},  32'(sram_we_n), 32'd1);
    chk({tag, " oe_n"},  32'(sram_oe_n), 32'd1);
    chk({tag, " dq_oe"}, 32'(sram_dq_oe), 32'd0);
    chk({tag, " addr"},  32'(sram_addr), 32'd0);
    chk({tag, " dq_out"}, 32'(sram_dq_out), 32'd0);
  endtask

  // Entered #1 after a posedge with the DUT in IDLE; leaves the same way.
  task automatic run_access(input vec_t v, input bit keep, output int done_cyc);
    logic [15:0] half;
    wr_en = v.wr; rd_en = v.rd; address = v.addr; write_data = v.wdata;
    @(negedge clk);
    chk("req idle ready", 32'(ready), 32'd0);
    chk_idle_pins("req idle");
    for (int k = 1; k <= 2 * W; k++) begin
      @(posedge clk); @(negedge clk);
      half = (k > W) ? v.wdata[31:16] : v.wdata[15:0];
      chk("busy ready", 32'(ready), 32'd0);
      chk("busy addr", 32'(sram_addr), 32'(v.exp_base) + ((k > W) ? 32'd1 : 32'd0));
      chk("busy we_n", 32'(sram_we_n), v.wr ? 32'd0 : 32'd1);
      chk("busy oe_n", 32'(sram_oe_n), v.wr ? 32'd1 : 32'd0);
      chk("busy dq_oe", 32'(sram_dq_oe), v.wr ? 32'd1 : 32'd0);
      chk("busy dq_out", 32'(sram_dq_out), v.wr ? 32'(half) : 32'd0);
    end
    @(posedge clk); @(negedge clk);
    done_cyc = cyc;
    if (v.wr) exp_wrc++; else exp_rdc++;
    chk("done ready", 32'(ready), 32'd1);
    chk("done read_data", read_data, v.exp_rd);
    chk_idle_pins("done");
`ifdef SRAM_ACCESS_COUNT_EN
    chk("done rd_count", rd_count, 32'(exp_rdc));
    chk("done wr_count", wr_count, 32'(exp_wrc));
`endif
    @(posedge clk); #1;
    if (!keep) begin
      wr_en = 1'b0; rd_en = 1'b0;
    end
  endtask

  initial begin
    int d0, d1;
    //           wr    rd    addr          wdata          exp_rd         base
    tbl[0] = '{1'b1, 1'b0, 32'd1028,     32'hDEADBEEF, 32'h00000000, 18'd2};
    tbl[1] = '{1'b0, 1'b1, 32'd1028,     32'h0,        32'hDEADBEEF, 18'd2};
    tbl[2] = '{1'b1, 1'b1, 32'd1024,     32'h12345678, 32'hDEADBEEF, 18'd0};
    tbl[3] = '{1'b0, 1'b1, 32'd1024,     32'h0,        32'h12345678, 18'd0};
    tbl[4] = '{1'b1, 1'b0, 32'h00080408, 32'hCAFEF00D, 32'h12345678, 18'd4};
    tbl[5] = '{1'b0, 1'b1, 32'd1032,     32'h0,        32'hCAFEF00D, 18'd4};
    tbl[6] = '{1'b1, 1'b0, 32'd1020,     32'hA5A55A5A, 32'hCAFEF00D, 18'h3FFFE};
    tbl[7] = '{1'b0, 1'b1, 32'd1020,     32'h0,        32'hA5A55A5A, 18'h3FFFE};
    tbl[8] = '{1'b0, 1'b1, 32'd1026,     32'h0,        32'h12345678, 18'd0};

    // Reset with a store request pending.
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b0; address = 32'd1024; write_data = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ready", 32'(ready), 32'd0);
    chk("rst read_data", read_data, 32'd0);
    chk_idle_pins("rst");
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0;

    // No request for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("noreq ready", 32'(ready), 32'd1);
      chk_idle_pins("noreq");
      @(posedge clk); #1;
    end

    for (int i = 0; i < 9; i++) run_access(tbl[i], 1'b0, d0);

    // Back-to-back loads with the request held through DONE/IDLE.
    run_access(tbl[1], 1'b1, d0);
    run_access(tbl[1], 1'b0, d1);
    chk("b2b spacing", 32'(d1 - d0), 32'd6);

    // Reset during the HIGH half of a load.
    rd_en = 1'b1; address = 32'd1028;
    repeat (W + 1) @(posedge clk);
    #1;
    chk("mid high addr", 32'(sram_addr), 32'd3);
    chk("mid high oe_n", 32'(sram_oe_n), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid rst ready", 32'(ready), 32'd0);
    chk("mid rst read_data", read_data, 32'd0);
    chk_idle_pins("mid rst");
`ifdef SRAM_ACCESS_COUNT_EN
    chk("mid rst rd_count", rd_count, 32'd0);
    chk("mid rst wr_count", wr_count, 32'd0);
`endif
    rst = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    chk("post rst ready", 32'(ready), 32'd1);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
